// File: rtl/axi_fir_lite.sv
// 4-tap Q1.15 FIR filter. Coefficients, control and a sample counter are
// reachable over an AXI4-Lite slave; samples flow on a valid-qualified stream.
module axi_fir_lite #(
  parameter int                 DATA_W    = 16,
  parameter int                 NTAPS     = 4,
  parameter logic [DATA_W-1:0]  COEFF_RST = 16'h2000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       axi_awaddr,
  input  logic [2:0]        axi_awprot,
  input  logic              axi_awvalid,
  output logic              axi_awready,
  input  logic [31:0]       axi_wdata,
  input  logic [3:0]        axi_wstrb,
  input  logic              axi_wvalid,
  output logic              axi_wready,
  output logic [1:0]        axi_bresp,
  output logic              axi_bvalid,
  input  logic              axi_bready,
  input  logic [31:0]       axi_araddr,
  input  logic [2:0]        axi_arprot,
  input  logic              axi_arvalid,
  output logic              axi_arready,
  output logic [31:0]       axi_rdata,
  output logic [1:0]        axi_rresp,
  output logic              axi_rvalid,
  input  logic              axi_rready,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              valid_out,
  output logic [DATA_W-1:0] data_out
);

  localparam int PW    = 2 * DATA_W;
  localparam int ACC_W = PW + 2;
  localparam int FRAC  = DATA_W - 1;
  localparam int NB    = DATA_W / 8;

  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [5:0]  IDX_CTRL    = 6'd0;
  localparam logic [5:0]  IDX_STATUS  = 6'd1;
  localparam logic [5:0]  IDX_ID      = 6'd2;
  localparam logic [5:0]  IDX_COEFF0  = 6'd3;
  localparam logic [5:0]  IDX_COUNT   = 6'd7;
  localparam logic [31:0] ID_VALUE    = 32'h4649_5204;

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 <<< (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(1 <<< (DATA_W - 1)));
  localparam logic [DATA_W-1:0] OUT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] OUT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  // AXI channel state
  logic              wr_ready_reg;
  logic              bvalid_reg;
  logic [1:0]        bresp_reg;
  logic              arready_reg;
  logic              rvalid_reg;
  logic [1:0]        rresp_reg;
  logic [31:0]       rdata_reg;

  // Register file
  logic              enable_reg;
  logic [31:0]       count_reg;
  logic signed [DATA_W-1:0] coeff_reg [NTAPS];

  // Datapath
  logic signed [DATA_W-1:0] x_reg    [NTAPS];
  logic signed [DATA_W-1:0] tap_in   [NTAPS];
  logic signed [PW-1:0]     prod_reg [NTAPS];
  logic                     v1_reg;
  logic                     v2_reg;
  logic signed [ACC_W-1:0]  acc_reg;
  logic signed [ACC_W-1:0]  acc_sum;
  logic signed [ACC_W-1:0]  acc_shift;
  logic [DATA_W-1:0]        sat_value;
  logic                     valid_out_reg;
  logic [DATA_W-1:0]        data_out_reg;

  logic        wr_fire;
  logic        rd_fire;
  logic [5:0]  wr_idx;
  logic [5:0]  rd_idx;
  logic [1:0]  wr_resp;
  logic        ctrl_write;
  logic        clear_cmd;
  logic        accept;
  logic [31:0] rd_data_next;
  logic [1:0]  rd_resp_next;
  logic        unused_bits;

  assign wr_idx     = axi_awaddr[7:2];
  assign rd_idx     = axi_araddr[7:2];
  assign wr_fire    = wr_ready_reg & axi_awvalid & axi_wvalid;
  assign rd_fire    = arready_reg & axi_arvalid;
  assign wr_resp    = (wr_idx <= IDX_COUNT) ? RESP_OKAY : RESP_SLVERR;
  assign ctrl_write = wr_fire && (wr_idx == IDX_CTRL) && axi_wstrb[0];
  assign clear_cmd  = ctrl_write && axi_wdata[1];
  assign accept     = enable_reg & valid_in;

  assign axi_awready = wr_ready_reg;
  assign axi_wready  = wr_ready_reg;
  assign axi_bvalid  = bvalid_reg;
  assign axi_bresp   = bresp_reg;
  assign axi_arready = arready_reg;
  assign axi_rvalid  = rvalid_reg;
  assign axi_rresp   = rresp_reg;
  assign axi_rdata   = rdata_reg;
  assign valid_out   = valid_out_reg;
  assign data_out    = data_out_reg;

  assign unused_bits = ^{axi_awprot, axi_arprot, axi_awaddr[31:8], axi_awaddr[1:0],
                         axi_araddr[31:8], axi_araddr[1:0], axi_wdata[31:DATA_W],
                         axi_wstrb[3:NB]};

  // Ready pulses for one cycle only when both AW and W are present, so
  // neither channel is ever accepted on its own.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ready_reg <= 1'b0;
      bvalid_reg   <= 1'b0;
      bresp_reg    <= RESP_OKAY;
    end else begin
      wr_ready_reg <= axi_awvalid & axi_wvalid & ~bvalid_reg & ~wr_ready_reg;
      if (wr_fire) begin
        bvalid_reg <= 1'b1;
        bresp_reg  <= wr_resp;
      end else if (bvalid_reg && axi_bready) begin
        bvalid_reg <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arready_reg <= 1'b0;
      rvalid_reg  <= 1'b0;
      rresp_reg   <= RESP_OKAY;
      rdata_reg   <= '0;
    end else begin
      arready_reg <= axi_arvalid & ~rvalid_reg & ~arready_reg;
      if (rd_fire) begin
        rvalid_reg <= 1'b1;
        rdata_reg  <= rd_data_next;
        rresp_reg  <= rd_resp_next;
      end else if (rvalid_reg && axi_rready) begin
        rvalid_reg <= 1'b0;
      end
    end
  end

  always_comb begin
    rd_data_next = '0;
    rd_resp_next = RESP_OKAY;
    case (rd_idx)
      IDX_CTRL:   rd_data_next = {31'd0, enable_reg};
      IDX_STATUS: rd_data_next = {31'd0, valid_out_reg};
      IDX_ID:     rd_data_next = ID_VALUE;
      IDX_COUNT:  rd_data_next = count_reg;
      6'd3, 6'd4, 6'd5, 6'd6: rd_data_next = '0;
      default:    rd_resp_next = RESP_SLVERR;
    endcase
    for (int k = 0; k < NTAPS; k++) begin
      if (rd_idx == IDX_COEFF0 + 6'(k)) begin
        rd_data_next = {{(32-DATA_W){1'b0}}, coeff_reg[k]};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enable_reg <= 1'b1;
    end else if (ctrl_write) begin
      enable_reg <= axi_wdata[0];
    end
  end

  // A clear written on the same edge as an accepted sample takes priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (clear_cmd) begin
      count_reg <= '0;
    end else if (accept) begin
      count_reg <= count_reg + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NTAPS; k++) begin
        coeff_reg[k] <= COEFF_RST;
      end
    end else if (wr_fire) begin
      for (int k = 0; k < NTAPS; k++) begin
        if (wr_idx == IDX_COEFF0 + 6'(k)) begin
          for (int b = 0; b < NB; b++) begin
            if (axi_wstrb[b]) begin
              coeff_reg[k][b*8 +: 8] <= axi_wdata[b*8 +: 8];
            end
          end
        end
      end
    end
  end

  // Tap k sees the sample that will sit in x_reg[k] after the accept edge.
  generate
    for (genvar gi = 0; gi < NTAPS; gi++) begin : g_tap
      if (gi == 0) begin : g_first
        assign tap_in[gi] = data_in;
      end else begin : g_rest
        assign tap_in[gi] = x_reg[gi-1];
      end
    end
  endgenerate

  // Products are formed on the accept edge from the coefficients current at
  // that edge, so a coefficient write affects only later samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NTAPS; k++) begin
        x_reg[k]    <= '0;
        prod_reg[k] <= '0;
      end
      v1_reg <= 1'b0;
    end else begin
      v1_reg <= accept;
      if (accept) begin
        for (int k = 0; k < NTAPS; k++) begin
          x_reg[k]    <= tap_in[k];
          prod_reg[k] <= PW'(coeff_reg[k]) * PW'(tap_in[k]);
        end
      end
    end
  end

  always_comb begin
    acc_sum = '0;
    for (int k = 0; k < NTAPS; k++) begin
      acc_sum = acc_sum + ACC_W'(prod_reg[k]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_reg <= '0;
      v2_reg  <= 1'b0;
    end else begin
      v2_reg <= v1_reg;
      if (v1_reg) begin
        acc_reg <= acc_sum;
      end
    end
  end

  always_comb begin
    acc_shift = acc_reg >>> FRAC;
    if (acc_shift > SAT_MAX) begin
      sat_value = OUT_MAX;
    end else if (acc_shift < SAT_MIN) begin
      sat_value = OUT_MIN;
    end else begin
      sat_value = acc_shift[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_out_reg <= 1'b0;
      data_out_reg  <= '0;
    end else begin
      valid_out_reg <= v2_reg;
      if (v2_reg) begin
        data_out_reg <= sat_value;
      end
    end
  end

endmodule

// File: tb/tb_axi_fir_lite.sv
// Self-checking bench for axi_fir_lite: register table, filter corner cases
// and randomized samples checked against an arithmetic FIR model.
module tb_axi_fir_lite;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] axi_awaddr;
  logic [2:0]  axi_awprot;
  logic        axi_awvalid;
  logic        axi_awready;
  logic [31:0] axi_wdata;
  logic [3:0]  axi_wstrb;
  logic        axi_wvalid;
  logic        axi_wready;
  logic [1:0]  axi_bresp;
  logic        axi_bvalid;
  logic        axi_bready;
  logic [31:0] axi_araddr;
  logic [2:0]  axi_arprot;
  logic        axi_arvalid;
  logic        axi_arready;
  logic [31:0] axi_rdata;
  logic [1:0]  axi_rresp;
  logic        axi_rvalid;
  logic        axi_rready;
  logic        valid_in;
  logic [15:0] data_in;
  logic        valid_out;
  logic [15:0] data_out;

  axi_fir_lite dut (
    .clk(clk), .rst(rst),
    .axi_awaddr(axi_awaddr), .axi_awprot(axi_awprot), .axi_awvalid(axi_awvalid),
    .axi_awready(axi_awready), .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_bresp(axi_bresp),
    .axi_bvalid(axi_bvalid), .axi_bready(axi_bready), .axi_araddr(axi_araddr),
    .axi_arprot(axi_arprot), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid),
    .axi_rready(axi_rready), .valid_in(valid_in), .data_in(data_in),
    .valid_out(valid_out), .data_out(data_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct { logic [15:0] y; int due; } exp_t;
  exp_t        exp_q[$];
  logic [15:0] out_log[$];
  longint      hist[4];
  longint      mcoef[4];
  bit          model_en;
  int unsigned model_count;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
    string       name;
  } vec_t;
  vec_t vt[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] fir_ref();
    longint acc = 0;
    for (int k = 0; k < 4; k++) acc += mcoef[k] * hist[k];
    acc = acc >>> 15;
    if (acc > 32767) acc = 32767;
    else if (acc < -32768) acc = -32768;
    return acc[15:0];
  endfunction

  task automatic model_reset();
    exp_q.delete();
    for (int k = 0; k < 4; k++) begin
      hist[k]  = 0;
      mcoef[k] = 64'sd8192;
    end
    model_en    = 1'b1;
    model_count = 0;
  endtask

  // Reference: every accepted sample yields one output two edges later.
  always @(posedge clk) begin
    cyc++;
    if (!rst && valid_in && model_en) begin
      for (int k = 3; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = longint'($signed(data_in));
      exp_q.push_back('{fir_ref(), cyc + 2});
      model_count++;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      check("valid_out_in_reset", {31'd0, valid_out}, 32'd0);
    end else if (valid_out) begin
      out_log.push_back(data_out);
      if (exp_q.size() == 0) begin
        check("spurious_valid_out", {31'd0, valid_out}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("data_out", {16'd0, data_out}, {16'd0, e.y});
        check("latency", cyc, e.due);
      end
    end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      check("missing_valid_out", {31'd0, valid_out}, 32'd1);
      void'(exp_q.pop_front());
    end
  end

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int hold, output logic [1:0] resp);
    bit ok;
    logic [5:0] idx;
    logic [15:0] c;
    @(negedge clk);
    axi_awaddr = addr; axi_wdata = data; axi_wstrb = strb;
    axi_awvalid = 1'b1; axi_wvalid = 1'b1; axi_bready = (hold == 0);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (axi_awready) ok = 1'b1;
    end
    if (!ok) check("awready_timeout", {31'd0, axi_awready}, 32'd1);
    else check("wready_with_awready", {31'd0, axi_wready}, 32'd1);
    @(negedge clk);
    axi_awvalid = 1'b0; axi_wvalid = 1'b0;
    check("awready_one_cycle", {31'd0, axi_awready}, 32'd0);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (axi_bvalid) ok = 1'b1;
      else @(negedge clk);
    end
    if (!ok) check("bvalid_timeout", {31'd0, axi_bvalid}, 32'd1);
    resp = axi_bresp;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("bvalid_hold", {31'd0, axi_bvalid}, 32'd1);
      check("bresp_hold", {30'd0, axi_bresp}, {30'd0, resp});
    end
    axi_bready = 1'b1;
    @(negedge clk);
    check("bvalid_drop", {31'd0, axi_bvalid}, 32'd0);
    axi_bready = 1'b0;
    idx = addr[7:2];
    if (idx == 6'd0 && strb[0]) begin
      model_en = data[0];
      if (data[1]) model_count = 0;
    end
    for (int k = 0; k < 4; k++) begin
      if (idx == 6'(3 + k)) begin
        c = mcoef[k][15:0];
        if (strb[0]) c[7:0] = data[7:0];
        if (strb[1]) c[15:8] = data[15:8];
        mcoef[k] = longint'($signed(c));
      end
    end
  endtask

  task automatic axi_read(input logic [31:0] addr, input int hold,
                          output logic [31:0] data, output logic [1:0] resp);
    bit ok;
    @(negedge clk);
    axi_araddr = addr; axi_arvalid = 1'b1; axi_rready = (hold == 0);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (axi_arready) ok = 1'b1;
    end
    if (!ok) check("arready_timeout", {31'd0, axi_arready}, 32'd1);
    @(negedge clk);
    axi_arvalid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (axi_rvalid) ok = 1'b1;
      else @(negedge clk);
    end
    if (!ok) check("rvalid_timeout", {31'd0, axi_rvalid}, 32'd1);
    data = axi_rdata;
    resp = axi_rresp;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("rvalid_hold", {31'd0, axi_rvalid}, 32'd1);
      check("rdata_hold", axi_rdata, data);
    end
    axi_rready = 1'b1;
    @(negedge clk);
    check("rvalid_drop", {31'd0, axi_rvalid}, 32'd0);
    axi_rready = 1'b0;
  endtask

  task automatic send(input logic [15:0] s);
    @(negedge clk);
    valid_in = 1'b1;
    data_in  = s;
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    valid_in = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic set_coeffs(input logic [15:0] c0, input logic [15:0] c1,
                            input logic [15:0] c2, input logic [15:0] c3);
    logic [1:0] r;
    logic [15:0] cs[4];
    cs = '{c0, c1, c2, c3};
    for (int k = 0; k < 4; k++) begin
      axi_write(32'h0C + 32'(4 * k), {16'd0, cs[k]}, 4'hF, 0, r);
      check("coeff_wr_resp", {30'd0, r}, 32'd0);
    end
  endtask

  function automatic void add_vec(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic [3:0] strb, input logic [31:0] exp_data,
                                  input logic [1:0] exp_resp, input string name);
    vt.push_back('{wr, addr, wdata, strb, exp_data, exp_resp, name});
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    int          n0;
    logic [31:0] cnt0;

    rst = 1'b1;
    axi_awaddr = '0; axi_awprot = '0; axi_awvalid = 1'b0; axi_wdata = '0; axi_wstrb = '0;
    axi_wvalid = 1'b0; axi_bready = 1'b0; axi_araddr = '0; axi_arprot = '0;
    axi_arvalid = 1'b0; axi_rready = 1'b0; valid_in = 1'b0; data_in = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_awready", {31'd0, axi_awready}, 32'd0);
    check("rst_wready", {31'd0, axi_wready}, 32'd0);
    check("rst_bvalid", {31'd0, axi_bvalid}, 32'd0);
    check("rst_arready", {31'd0, axi_arready}, 32'd0);
    check("rst_rvalid", {31'd0, axi_rvalid}, 32'd0);
    check("rst_bresp", {30'd0, axi_bresp}, 32'd0);
    check("rst_rresp", {30'd0, axi_rresp}, 32'd0);
    check("rst_rdata", axi_rdata, 32'd0);
    check("rst_data_out", {16'd0, data_out}, 32'd0);
    rst = 1'b0;

    add_vec(0, 32'h0C, 0, 0, 32'h0000_2000, 2'b00, "coeff0_reset");
    add_vec(0, 32'h08, 0, 0, 32'h4649_5204, 2'b00, "id");
    add_vec(0, 32'h00, 0, 0, 32'h0000_0001, 2'b00, "ctrl_reset");
    add_vec(0, 32'h1C, 0, 0, 32'h0000_0000, 2'b00, "count_reset");
    add_vec(0, 32'h04, 0, 0, 32'h0000_0000, 2'b00, "status_idle");
    add_vec(1, 32'h0C, 32'h0000_2000, 4'hF, 0, 2'b00, "wr_coeff0");
    add_vec(1, 32'h10, 32'h0000_E000, 4'hF, 0, 2'b00, "wr_coeff1");
    add_vec(1, 32'h14, 32'h0000_E000, 4'hF, 0, 2'b00, "wr_coeff2");
    add_vec(1, 32'h18, 32'h0000_2000, 4'hF, 0, 2'b00, "wr_coeff3");
    add_vec(0, 32'h0C, 0, 0, 32'h0000_2000, 2'b00, "rd_coeff0");
    add_vec(0, 32'h10, 0, 0, 32'h0000_E000, 2'b00, "rd_coeff1");
    add_vec(0, 32'h14, 0, 0, 32'h0000_E000, 2'b00, "rd_coeff2");
    add_vec(0, 32'h18, 0, 0, 32'h0000_2000, 2'b00, "rd_coeff3");
    add_vec(1, 32'h08, 32'hFFFF_FFFF, 4'hF, 0, 2'b00, "wr_id_ro");
    add_vec(0, 32'h08, 0, 0, 32'h4649_5204, 2'b00, "id_unchanged");
    add_vec(1, 32'h40, 32'h1234_5678, 4'hF, 0, 2'b10, "wr_unmapped");
    add_vec(0, 32'h40, 0, 0, 32'h0000_0000, 2'b10, "rd_unmapped");
    add_vec(1, 32'h10, 32'h00AB_CD34, 4'h1, 0, 2'b00, "wr_coeff1_strb");
    add_vec(0, 32'h10, 0, 0, 32'h0000_E034, 2'b00, "rd_coeff1_strb");
    add_vec(1, 32'h11, 32'hFFFF_E000, 4'hF, 0, 2'b00, "wr_coeff1_lowbits");
    add_vec(0, 32'h13, 0, 0, 32'h0000_E000, 2'b00, "rd_coeff1_upper0");
    add_vec(0, 32'h1E, 0, 0, 32'h0000_0000, 2'b00, "rd_count_alias");

    foreach (vt[i]) begin
      if (vt[i].wr) begin
        axi_write(vt[i].addr, vt[i].wdata, vt[i].strb, 0, r);
        check({vt[i].name, "_bresp"}, {30'd0, r}, {30'd0, vt[i].exp_resp});
        $display("WRITE %s addr=%h data=%h strb=%h bresp=%0d", vt[i].name, vt[i].addr, vt[i].wdata, vt[i].strb, r);
      end else begin
        axi_read(vt[i].addr, 0, d, r);
        check(vt[i].name, d, vt[i].exp_data);
        check({vt[i].name, "_rresp"}, {30'd0, r}, {30'd0, vt[i].exp_resp});
        $display("READ  %s addr=%h data=%h rresp=%0d", vt[i].name, vt[i].addr, d, r);
      end
    end

    // High-pass step response
    out_log.delete();
    for (int i = 0; i < 4; i++) send(16'h7FFF);
    for (int i = 0; i < 12; i++) send(16'h8000);
    idle(6);
    check("hp_pulses", out_log.size(), 16);
    if (out_log.size() >= 4) begin
      check("hp_out0", {16'd0, out_log[0]}, 32'h1FFF);
      check("hp_out1", {16'd0, out_log[1]}, 32'h0000);
      check("hp_out2", {16'd0, out_log[2]}, 32'hE000);
      check("hp_out3", {16'd0, out_log[3]}, 32'h0000);
    end
    axi_read(32'h1C, 0, d, r);
    check("hp_count", d, 32'd16);
    $display("SEQ   highpass pulses=%0d count=%0d", out_log.size(), d);

    // Moving average ramps to full scale
    set_coeffs(16'h2000, 16'h2000, 16'h2000, 16'h2000);
    out_log.delete();
    for (int i = 0; i < 8; i++) send(16'h7FFF);
    idle(6);
    check("avg_pulses", out_log.size(), 8);
    if (out_log.size() > 0) check("avg_final", {16'd0, out_log[$]}, 32'h7FFF);
    $display("SEQ   average final=%h", out_log.size() > 0 ? out_log[$] : 16'h0);

    // Saturation in both directions
    set_coeffs(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    out_log.delete();
    for (int i = 0; i < 4; i++) send(16'h7FFF);
    idle(6);
    if (out_log.size() > 0) check("sat_pos", {16'd0, out_log[$]}, 32'h7FFF);
    out_log.delete();
    for (int i = 0; i < 4; i++) send(16'h8000);
    idle(6);
    if (out_log.size() > 0) check("sat_neg", {16'd0, out_log[$]}, 32'h8000);
    set_coeffs(16'h8000, 16'h8000, 16'h8000, 16'h8000);
    out_log.delete();
    for (int i = 0; i < 4; i++) send(16'h8000);
    idle(6);
    if (out_log.size() > 0) check("sat_minmin", {16'd0, out_log[$]}, 32'h7FFF);
    $display("SEQ   saturation done");

    // Backpressure on both response channels, unmapped access
    axi_write(32'h0C, 32'h0000_1111, 4'hF, 5, r);
    check("hold_bresp", {30'd0, r}, 32'd0);
    axi_read(32'h40, 5, d, r);
    check("hold_slverr_rdata", d, 32'd0);
    check("hold_slverr_rresp", {30'd0, r}, 32'd2);
    $display("SEQ   hold rdata=%h rresp=%0d", d, r);

    // Disable: samples ignored, count frozen, then clear
    axi_read(32'h1C, 0, cnt0, r);
    check("count_before_disable", cnt0, model_count);
    axi_write(32'h00, 32'h0, 4'hF, 0, r);
    out_log.delete();
    for (int i = 0; i < 3; i++) send(16'h1234);
    idle(6);
    check("disabled_pulses", out_log.size(), 0);
    axi_read(32'h1C, 0, d, r);
    check("disabled_count", d, cnt0);
    axi_write(32'h00, 32'h3, 4'hF, 0, r);
    axi_read(32'h1C, 0, d, r);
    check("count_cleared", d, 32'd0);
    axi_read(32'h00, 0, d, r);
    check("ctrl_clear_reads0", d, 32'd1);
    $display("SEQ   enable/clear count=%0d", d);

    // Randomized coefficients and sample stream
    for (int k = 0; k < 4; k++) begin
      axi_write(32'h0C + 32'(4 * k), {16'd0, 16'($urandom)}, 4'hF, 0, r);
    end
    n0 = model_count;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      valid_in = ($urandom_range(0, 9) < 7);
      data_in  = 16'($urandom);
    end
    idle(6);
    axi_read(32'h1C, 0, d, r);
    check("random_count", d, model_count);
    $display("SEQ   random accepted=%0d count=%0d", model_count - n0, d);

    // Reset while samples are in flight
    send(16'h4000);
    send(16'h4000);
    @(posedge clk);
    #2;
    rst = 1'b1;
    valid_in = 1'b0;
    model_reset();
    out_log.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("flush_pulses", out_log.size(), 0);
    axi_read(32'h0C, 0, d, r);
    check("flush_coeff0", d, 32'h2000);
    axi_read(32'h1C, 0, d, r);
    check("flush_count", d, 32'd0);
    $display("SEQ   reset flush pulses=%0d", out_log.size());

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
